systolic_output_collector: RTL

Receive-side collector at the bottom edge of the systolic array. Captures the column-skewed partial sums leaving the array and re-aligns them into whole result rows. Buffers the rows in a small FIFO and hands them to the downstream consumer over a valid/ready handshake. Column N-1 of a row arrives N-1 cycles after column 0; this block removes that skew so the consumer sees one complete row per transfer.

---
 rtl/systolic_output_collector.sv | 131 +++++++++++++
 1 files changed

// File: rtl/systolic_output_collector.sv
// Bottom-edge collector for the systolic array: removes the column skew from the
// partial sums and buffers whole rows in a FIFO. Optional clamp: COLLECTOR_RELU_EN.
module systolic_output_collector #(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int PARTIAL_SUM_WIDTH = 19,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] partial_sum_in_flat,
  input  logic [SYSTOLIC_SIZE-1:0]                   col_disable,
  input  logic                                       clear_overflow,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] out_data_flat,
  output logic [$clog2(FIFO_DEPTH):0]                fifo_count,
  output logic                                       overflow
);

  localparam int N  = SYSTOLIC_SIZE;
  localparam int W  = PARTIAL_SUM_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Output handshake: a row moves when out_valid && out_ready on a rising edge;
  // out_valid depends only on registered state and the head row is held until taken.

  logic [N-1:0][W-1:0] aligned;
  logic [N-2:0]        vld_q;
  logic                wr_en;

  // Column j enters j cycles late, so it waits N-1-j cycles to line up with column N-1.
  for (genvar j = 0; j < N; j++) begin : g_col
    localparam int D = N - 1 - j;
    if (D == 0) begin : g_pass
      assign aligned[j] = partial_sum_in_flat[j*W +: W];
    end else begin : g_dly
      logic [W-1:0] dly_q [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < D; k++) dly_q[k] <= '0;
        end else begin
          dly_q[0] <= partial_sum_in_flat[j*W +: W];
          for (int k = 1; k < D; k++) dly_q[k] <= dly_q[k-1];
        end
      end
      assign aligned[j] = dly_q[D-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < N - 1; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  assign wr_en = vld_q[N-2];

  logic [N-1:0][W-1:0] wr_row;
  logic [W-1:0]        col_v;

  always_comb begin
    wr_row = '0;
    col_v  = '0;
    for (int j = 0; j < N; j++) begin
      col_v = aligned[j];
`ifdef COLLECTOR_RELU_EN
      if (col_v[W-1]) col_v = '0;
`endif
      if (col_disable[j]) col_v = '0;
      wr_row[j] = col_v;
    end
  end

  logic [N-1:0][W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       count_next;
  logic                overflow_q;
  logic                full;
  logic                rd;
  logic                wr_accept;
  logic                drop;

  assign out_valid  = (count_q != '0);
  assign full       = (count_q == DEPTH_C);
  assign rd         = out_valid && out_ready;
  // A read in the same cycle frees the slot, so a full FIFO still takes the row.
  assign wr_accept  = wr_en && (!full || rd);
  assign drop       = wr_en && full && !rd;

  always_comb begin
    count_next = count_q;
    case ({wr_accept, rd})
      2'b10:   count_next = count_q + CW'(1);
      2'b01:   count_next = count_q - CW'(1);
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_accept) mem[wr_ptr] <= wr_row;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PW'(1);
      if (rd)        rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_next;
      if (drop)                overflow_q <= 1'b1;
      else if (clear_overflow) overflow_q <= 1'b0;
    end
  end

  // Gating with out_valid keeps the bus at zero while empty, including after reset.
  assign out_data_flat = out_valid ? mem[rd_ptr] : '0;
  assign fifo_count    = count_q;
  assign overflow      = overflow_q;

endmodule
